// File: rtl/cdma_rd_mux_if.sv
// AXI3 read address/data port of the CDMA read mux.
// master = mux side, slave = memory side.
interface cdma_rd_mux_if #(
  parameter int IDW = 4
);
  logic [IDW-1:0] arid;
  logic [31:0]    araddr;
  logic [3:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic [1:0]     arlock;
  logic [3:0]     arcache;
  logic [2:0]     arprot;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cdma_rd_mux.sv
// N-channel CDMA read engine: 4 KB-safe burst split,
// round-robin AR issue, RID-steered read data return.
module cdma_rd_mux #(
  parameter int            NCH       = 2,
  parameter int            IDW       = 4,
  parameter int            MAX_BURST = 16,
  parameter logic [NCH-1:0] BUF_MASK = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_dma_halt,
  input  logic              cfg_bf,
  input  logic              cfg_cf,
  input  logic [5:0]        buf_empty_word,
  input  logic [NCH-1:0]    dma_r_req,
  input  logic [NCH*32-1:0] dma_r_addr,
  input  logic [NCH*16-1:0] dma_r_len,
  output logic [NCH-1:0]    dma_r_ack,
  output logic [NCH-1:0]    dma_dvld,
  input  logic [NCH-1:0]    dma_dack,
  output logic [31:0]       dma_rdata,
  output logic [3:0]        dma_rbe,
  output logic              dma_rd_last,
  output logic [NCH-1:0]    rd_err,
  input  logic [NCH-1:0]    clr_rd_err,
  cdma_rd_mux_if.master     axi
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]  st_q    [NCH];
  logic [1:0]  st_d    [NCH];
  logic [31:0] addr_q  [NCH];
  logic [31:0] addr_d  [NCH];
  logic [14:0] wl_q    [NCH];
  logic [14:0] wl_d    [NCH];
  logic [14:0] rx_q    [NCH];
  logic [14:0] rx_d    [NCH];
  logic [1:0]  foff_q  [NCH];
  logic [1:0]  foff_d  [NCH];
  logic [1:0]  loff_q  [NCH];
  logic [1:0]  loff_d  [NCH];
  logic        first_q [NCH];
  logic        first_d [NCH];

  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] err_q, err_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           arvalid_q, arvalid_d;
  logic [IDW-1:0] arid_q, arid_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [3:0]     arlen_q, arlen_d;

  logic [16:0]    sum17 [NCH];
  logic [14:0]    wrd   [NCH];
  logic [14:0]    room  [NCH];
  logic [14:0]    bw    [NCH];
  logic [NCH-1:0] elig;
  logic           gnt_vld;
  logic [PW-1:0]  gsel;
  int             gidx;
  logic           ar_hs;
  logic [4:0]     hs_beats;
  logic           hit;
  logic           r_acc;
  logic [PW-1:0]  rsel;
  logic [3:0]     fbe, lbe;

  assign ar_hs    = arvalid_q & axi.arready;
  assign hs_beats = {1'b0, arlen_q} + 5'd1;

  // Burst size and eligibility per channel
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      sum17[i] = {15'b0, dma_r_addr[i*32 +: 2]}
               + {1'b0, dma_r_len[i*16 +: 16]};
      wrd[i]   = 15'((sum17[i] >> 2) + 17'd1);
      room[i]  = 15'(11'd1024 - {1'b0, addr_q[i][11:2]});
      bw[i]    = wl_q[i];
      if (room[i] < bw[i]) bw[i] = room[i];
      if (15'(MAX_BURST) < bw[i]) bw[i] = 15'(MAX_BURST);
      elig[i]  = (st_q[i] == S_ISSUE) && !cfg_dma_halt
               && !(arvalid_q && arid_q == IDW'(i))
               && (!BUF_MASK[i] || {9'b0, buf_empty_word} >= bw[i]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gsel    = ptr_q;
    gidx    = 0;
    for (int k = 1; k <= NCH; k++) begin
      gidx = (int'(ptr_q) + k) % NCH;
      if (!gnt_vld && elig[PW'(gidx)]) begin
        gnt_vld = 1'b1;
        gsel    = PW'(gidx);
      end
    end
  end

  // AR register: a new grant may load in the handshake cycle
  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    ptr_d     = ptr_q;
    if (ar_hs) arvalid_d = 1'b0;
    if ((!arvalid_q || axi.arready) && gnt_vld) begin
      arvalid_d = 1'b1;
      arid_d    = IDW'(gsel);
      araddr_d  = {addr_q[gsel][31:2], 2'b00};
      arlen_d   = 4'(bw[gsel] - 15'd1);
      ptr_d     = gsel;
    end
  end

  always_comb begin
    hit  = 1'b0;
    rsel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (axi.rid == IDW'(i) && st_q[i] == S_WAIT) begin
        hit  = 1'b1;
        rsel = PW'(i);
      end
    end
    dma_dvld       = '0;
    dma_dvld[rsel] = hit & axi.rvalid;
    axi.rready     = hit ? dma_dack[rsel] : axi.rvalid;
    r_acc          = hit & axi.rvalid & dma_dack[rsel];
    fbe = first_q[rsel] ? (4'hF << foff_q[rsel]) : 4'hF;
    lbe = (rx_q[rsel] == 15'd1) ?
          (4'hF >> (2'd3 - loff_q[rsel])) : 4'hF;
    dma_rbe     = hit ? (fbe & lbe) : 4'h0;
    dma_rd_last = hit & axi.rvalid & (rx_q[rsel] == 15'd1);
  end

  always_comb begin
    ack_d = '0;
    err_d = err_q & ~clr_rd_err;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]    = st_q[i];
      addr_d[i]  = addr_q[i];
      wl_d[i]    = wl_q[i];
      rx_d[i]    = rx_q[i];
      foff_d[i]  = foff_q[i];
      loff_d[i]  = loff_q[i];
      first_d[i] = first_q[i];
      unique case (1'b1)
        st_q[i] == S_IDLE: if (dma_r_req[i]) begin
          ack_d[i]   = 1'b1;
          st_d[i]    = S_ISSUE;
          addr_d[i]  = dma_r_addr[i*32 +: 32];
          wl_d[i]    = wrd[i];
          rx_d[i]    = wrd[i];
          foff_d[i]  = dma_r_addr[i*32 +: 2];
          loff_d[i]  = sum17[i][1:0];
          first_d[i] = 1'b1;
        end
        st_q[i] == S_ISSUE: if (ar_hs && arid_q == IDW'(i)) begin
          addr_d[i] = {addr_q[i][31:2], 2'b00}
                    + {25'b0, hs_beats, 2'b00};
          wl_d[i]   = wl_q[i] - {10'b0, hs_beats};
          st_d[i]   = S_WAIT;
        end
        st_q[i] == S_WAIT: if (r_acc && rsel == PW'(i)) begin
          rx_d[i]    = rx_q[i] - 15'd1;
          first_d[i] = 1'b0;
          if (axi.rresp != 2'b00) err_d[i] = 1'b1;
          if (rx_q[i] == 15'd1) st_d[i] = S_IDLE;
          else if (axi.rlast && wl_q[i] != 15'd0) st_d[i] = S_ISSUE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]    <= S_IDLE;
        addr_q[i]  <= '0;
        wl_q[i]    <= '0;
        rx_q[i]    <= '0;
        foff_q[i]  <= '0;
        loff_q[i]  <= '0;
        first_q[i] <= 1'b0;
      end
      ack_q     <= '0;
      err_q     <= '0;
      ptr_q     <= PW'(NCH - 1);
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]    <= st_d[i];
        addr_q[i]  <= addr_d[i];
        wl_q[i]    <= wl_d[i];
        rx_q[i]    <= rx_d[i];
        foff_q[i]  <= foff_d[i];
        loff_q[i]  <= loff_d[i];
        first_q[i] <= first_d[i];
      end
      ack_q     <= ack_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
    end
  end

  assign dma_r_ack   = ack_q;
  assign rd_err      = err_q;
  assign dma_rdata   = axi.rdata;
  assign axi.arvalid = arvalid_q;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arprot  = 3'b000;
  assign axi.arcache = {2'b00, cfg_cf, cfg_bf};

endmodule

// File: tb/tb_cdma_rd_mux.sv
// Directed bench for cdma_rd_mux: NCH=2, channel 1 buffer-gated,
// a small AXI read slave driven from tasks.
module tb_cdma_rd_mux;

  logic        clk;
  logic        rstn;
  logic        cfg_dma_halt;
  logic        cfg_bf;
  logic        cfg_cf;
  logic [5:0]  buf_empty_word;
  logic [1:0]  dma_r_req;
  logic [63:0] dma_r_addr;
  logic [31:0] dma_r_len;
  logic [1:0]  dma_r_ack;
  logic [1:0]  dma_dvld;
  logic [1:0]  dma_dack;
  logic [31:0] dma_rdata;
  logic [3:0]  dma_rbe;
  logic        dma_rd_last;
  logic [1:0]  rd_err;
  logic [1:0]  clr_rd_err;

  int n_chk;
  int n_fail;

  cdma_rd_mux_if #(.IDW(4)) axi ();

  cdma_rd_mux #(
    .NCH(2), .IDW(4), .MAX_BURST(16), .BUF_MASK(2'b10)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cfg_dma_halt(cfg_dma_halt),
    .cfg_bf(cfg_bf),
    .cfg_cf(cfg_cf),
    .buf_empty_word(buf_empty_word),
    .dma_r_req(dma_r_req),
    .dma_r_addr(dma_r_addr),
    .dma_r_len(dma_r_len),
    .dma_r_ack(dma_r_ack),
    .dma_dvld(dma_dvld),
    .dma_dack(dma_dack),
    .dma_rdata(dma_rdata),
    .dma_rbe(dma_rbe),
    .dma_rd_last(dma_rd_last),
    .rd_err(rd_err),
    .clr_rd_err(clr_rd_err),
    .axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic request(input int ch,
                         input logic [31:0] a,
                         input logic [15:0] l);
    int lat;
    lat = 99;
    @(negedge clk);
    dma_r_addr[ch*32 +: 32] = a;
    dma_r_len[ch*16 +: 16]  = l;
    dma_r_req[ch]           = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (dma_r_ack[ch]) begin
        lat = k;
        break;
      end
    end
    dma_r_req[ch] = 1'b0;
    check("ack_latency", lat, 1);
  endtask

  task automatic wait_ar();
    int k;
    k = 0;
    while (!axi.arvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ar_wait", {31'b0, axi.arvalid}, 1);
  endtask

  task automatic ar_accept();
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
  endtask

  task automatic expect_ar(input logic [31:0] a,
                           input logic [3:0] len,
                           input logic [3:0] id);
    wait_ar();
    check("araddr", axi.araddr, a);
    check("arlen", axi.arlen, len);
    check("arid", axi.arid, id);
    check("arsize", axi.arsize, 3'b010);
    check("arburst", axi.arburst, 2'b01);
    check("arcache", axi.arcache, 4'b0001);
    ar_accept();
  endtask

  task automatic beat(input logic [3:0] id, input logic last,
                      input logic [1:0] resp, input logic [1:0] dv,
                      input logic [3:0] be, input logic rl);
    axi.rid    = id;
    axi.rvalid = 1'b1;
    axi.rlast  = last;
    axi.rresp  = resp;
    axi.rdata  = $urandom;
    #1;
    check("dvld", dma_dvld, dv);
    check("rbe", dma_rbe, be);
    check("rd_last", dma_rd_last, rl);
    check("rready", axi.rready, 1);
    check("rdata", dma_rdata, axi.rdata);
    @(negedge clk);
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  task automatic burst(input logic [3:0] id, input int n,
                       input logic [1:0] dv, input logic [3:0] fbe,
                       input logic [3:0] lbe, input logic fin,
                       input int err_at);
    logic [3:0] be;
    for (int b = 0; b < n; b++) begin
      be = 4'hF;
      if (b == 0) be = be & fbe;
      if (b == n - 1 && fin) be = be & lbe;
      beat(id, b == n - 1, (b == err_at) ? 2'b10 : 2'b00, dv, be,
           fin && b == n - 1);
    end
  endtask

  task automatic no_ar(input int cyc);
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      check("no_ar", axi.arvalid, 0);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_arlen", axi.arlen, 0);
    check("rst_arid", axi.arid, 0);
    check("rst_ack", dma_r_ack, 0);
    check("rst_dvld", dma_dvld, 0);
    check("rst_rd_last", dma_rd_last, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rready", axi.rready, 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rstn = 1'b0;
    cfg_dma_halt = 1'b0;
    cfg_bf = 1'b1;
    cfg_cf = 1'b0;
    buf_empty_word = 6'd63;
    dma_r_req = '0;
    dma_r_addr = '0;
    dma_r_len = '0;
    dma_dack = 2'b11;
    clr_rd_err = '0;
    axi.arready = 1'b0;
    axi.rid = '0;
    axi.rdata = '0;
    axi.rresp = '0;
    axi.rlast = 1'b0;
    axi.rvalid = 1'b0;
    @(negedge clk);
    do_reset();

    // aligned 64-byte request
    request(0, 32'h1000, 16'd63);
    expect_ar(32'h1000, 4'd15, 4'd0);
    burst(4'd0, 16, 2'b01, 4'hF, 4'hF, 1'b1, -1);

    // unaligned two-word request
    request(0, 32'h2002, 16'd4);
    expect_ar(32'h2000, 4'd1, 4'd0);
    burst(4'd0, 2, 2'b01, 4'b1100, 4'b0111, 1'b1, -1);

    // 4 KB boundary split
    request(0, 32'h0FF8, 16'd15);
    expect_ar(32'h0FF8, 4'd1, 4'd0);
    burst(4'd0, 2, 2'b01, 4'hF, 4'hF, 1'b0, -1);
    expect_ar(32'h1000, 4'd1, 4'd0);
    burst(4'd0, 2, 2'b01, 4'hF, 4'hF, 1'b1, -1);

    // reset mid-burst, late beat dropped
    request(0, 32'h8000, 16'd15);
    expect_ar(32'h8000, 4'd3, 4'd0);
    do_reset();
    axi.rid = 4'd0;
    axi.rvalid = 1'b1;
    #1;
    check("late_rready", axi.rready, 1);
    check("late_dvld", dma_dvld, 0);
    check("late_rd_last", dma_rd_last, 0);
    @(negedge clk);
    axi.rvalid = 1'b0;

    // two channels together: grants 0, 1, 0
    dma_r_addr = {32'h4000, 32'h3000};
    dma_r_len  = {16'd7, 16'd127};
    dma_r_req  = 2'b11;
    @(negedge clk);
    check("dual_ack", dma_r_ack, 2'b11);
    dma_r_req = 2'b00;
    expect_ar(32'h3000, 4'd15, 4'd0);
    expect_ar(32'h4000, 4'd1, 4'd1);
    beat(4'd0, 1'b0, 2'b00, 2'b01, 4'hF, 1'b0);
    beat(4'd1, 1'b0, 2'b00, 2'b10, 4'hF, 1'b0);
    beat(4'd0, 1'b0, 2'b00, 2'b01, 4'hF, 1'b0);
    beat(4'd1, 1'b1, 2'b00, 2'b10, 4'hF, 1'b1);
    dma_dack = 2'b10;
    axi.rid = 4'd0;
    axi.rvalid = 1'b1;
    #1;
    check("stall_rready", axi.rready, 0);
    check("stall_dvld", dma_dvld, 2'b01);
    @(negedge clk);
    dma_dack = 2'b11;
    for (int b = 2; b < 16; b++)
      beat(4'd0, b == 15, 2'b00, 2'b01, 4'hF, 1'b0);
    expect_ar(32'h3040, 4'd15, 4'd0);
    burst(4'd0, 16, 2'b01, 4'hF, 4'hF, 1'b1, -1);

    // buffer gating on channel 1, channel 0 unaffected
    buf_empty_word = 6'd8;
    request(1, 32'h5000, 16'd63);
    request(0, 32'h6000, 16'd15);
    expect_ar(32'h6000, 4'd3, 4'd0);
    burst(4'd0, 4, 2'b01, 4'hF, 4'hF, 1'b1, -1);
    no_ar(4);
    buf_empty_word = 6'd16;
    expect_ar(32'h5000, 4'd15, 4'd1);
    burst(4'd1, 16, 2'b10, 4'hF, 4'hF, 1'b1, 3);
    check("err_set", rd_err, 2'b10);
    no_ar(2);
    check("err_sticky", rd_err, 2'b10);
    clr_rd_err = 2'b10;
    @(negedge clk);
    clr_rd_err = 2'b00;
    check("err_clr", rd_err, 2'b00);

    // halt during arvalid
    request(0, 32'h7000, 16'd127);
    wait_ar();
    cfg_dma_halt = 1'b1;
    @(negedge clk);
    check("halt_hold", axi.arvalid, 1);
    check("halt_addr", axi.araddr, 32'h7000);
    ar_accept();
    burst(4'd0, 16, 2'b01, 4'hF, 4'hF, 1'b0, -1);
    no_ar(5);
    cfg_dma_halt = 1'b0;
    expect_ar(32'h7040, 4'd15, 4'd0);
    burst(4'd0, 16, 2'b01, 4'hF, 4'hF, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdma_rd_mux.md
# cdma_rd_mux

Parametrised N-channel read engine between the CDMA read requesters (command fetch, 2D read command generator, future channels) and a single AXI3 read-address/read-data port. It accepts one byte-granular request per channel, splits it into 4 KB-safe INCR bursts, and issues those bursts round-robin with AXI ID equal to the channel index. Returned data is steered back by RID, with per-beat byte enables and a request-last flag. It is the successor of the fixed two-channel read bridge: channel count, burst cap and buffer gating are configurable, and multiple bursts can be outstanding (one per channel).

## Interface
- NCH, 2: number of request channels; 1..16, must satisfy NCH <= 2^IDW.
- IDW, 4: AXI ID width.
- MAX_BURST, 16: maximum beats per burst, 1..16.
- BUF_MASK, {NCH{1'b0}}: bit i set means channel i issues a burst only when buf_empty_word >= burst beats.
- clk  in  1  clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- cfg_dma_halt  in  1  1: issue no new AR; bursts already in flight complete.
- cfg_bf, cfg_cf  in  1 each  drive arcache[0] and arcache[1].
- buf_empty_word  in  6  free 32b words in the downstream data buffer.
- dma_r_req  in  NCH  level request, held until ack.
- dma_r_addr  in  NCH*32  byte start address, any alignment.
- dma_r_len  in  NCH*16  byte length, counted from 0.
- dma_r_ack  out  NCH  1-cycle acceptance pulse.
- dma_dvld  out  NCH  read data valid for channel i.
- dma_dack  in  NCH  channel i accepts the current beat.
- dma_rdata  out  32  shared read data (rdata passthrough).
- dma_rbe  out  4  byte valid for the current beat.
- dma_rd_last  out  1  current beat is the last beat of the request.
- rd_err  out  NCH  sticky: a nonzero RRESP was seen on channel i.
- clr_rd_err  in  NCH  clears rd_err[i].
- arid  out  IDW; araddr  out  32; arlen  out  4; arsize  out  3; arburst  out  2; arlock  out  2; arcache  out  4; arprot  out  3; arvalid  out  1; arready  in  1.
- rid  in  IDW; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.

## Operation
- Each channel has a context: cur_addr, words_left (10+ bits), rx_left, first_off, last_off, and states IDLE / ISSUE / WAIT.
- Acceptance: in IDLE with dma_r_req[i]=1:
  - load the context;
  - words = ((addr[1:0] + len) >> 2) + 1, computed at 17 bits;
  - first_off = addr[1:0];
  - last_off = (addr + len)[1:0];
  - pulse dma_r_ack[i];
  - go to ISSUE.
- Burst sizing: beats = min(MAX_BURST, words_left, 1024 - cur_addr[11:2]).
- AR fields:
  - araddr = {cur_addr[31:2], 2'b00};
  - arlen = beats - 1;
  - arid = i;
  - arsize = 3'b010, arburst = 2'b01, arlock = 0, arprot = 0;
  - arcache = {2'b00, cfg_cf, cfg_bf}.
- Eligible to issue: channel in ISSUE, no burst outstanding on it, cfg_dma_halt = 0, and (BUF_MASK[i] = 0 or buf_empty_word >= beats).
- Arbitration: round-robin among eligible channels, starting after the last-granted channel.
- Issue state: arvalid and all AR fields stay stable until arready.
- On the AR handshake:
  - cur_addr += beats*4 (word-aligned);
  - words_left -= beats;
  - mark the channel outstanding with its beat count.
- Data return: the channel is selected by rid.
  - dma_dvld[rid] = rvalid, all other dma_dvld bits 0;
  - rready = dma_dack[rid].
- dma_rbe per beat:
  - first beat of the request: 4'b1111 << first_off;
  - last beat of the request: 4'b1111 >> (3 - last_off);
  - a single-beat request is the AND of the two;
  - all other beats: 4'b1111.
- dma_rd_last = 1 on the beat where rx_left = 1.
- rlast clears the channel's outstanding flag.
- Return to IDLE when rx_left reaches 0 (words_left is already 0 by then). An rlast that arrives before words_left = 0 returns the channel to ISSUE.
- Errors: rresp != 0 on an accepted beat sets rd_err[rid]. Data is still delivered.
- Simultaneous set and clr_rd_err on the same bit: set wins.
- An rid >= NCH is accepted with rready = 1 and dropped. No channel sees dvld.

## Timing
- Reset values:
  - all contexts IDLE;
  - arvalid, rready, dma_r_ack, dma_dvld, dma_rd_last, rd_err = 0;
  - araddr, arlen, arid = 0;
  - round-robin pointer = NCH-1.
- Latency from req to ack: 1 cycle (registered).
- Latency from ack to first arvalid: >= 1 cycle, for the arbitration register.
- Back-to-back AR: a new arvalid is allowed the cycle after arready.
- R path: combinational from rid/rvalid/dack to dvld/rready. No R-side buffering.
- Reset mid-burst: all contexts are abandoned. Late R beats after reset are dropped as described for rid >= NCH, because no channel is outstanding.
- Halt: asserting cfg_dma_halt while arvalid is high does not drop arvalid. The current AR completes; the next one is blocked.

## Test plan
- Aligned request, channel 0: addr 0x1000, len 63 -> one AR with araddr 0x1000, arlen 15, arid 0; 16 beats; rbe 0xF on every beat; rd_last on beat 16.
- Unaligned request: addr 0x2002, len 4 -> AR araddr 0x2000, arlen 1; beat 1 rbe 4'b1100; beat 2 rbe 4'b0111 with rd_last.
- 4 KB split: addr 0x0FF8, len 15 -> two ARs, (0x0FF8, arlen 1) then (0x1000, arlen 1); rd_last only on the fourth beat.
- Two channels requesting together, NCH=2: grants alternate 0, 1, 0; R beats interleaved by rid route to the correct dma_dvld bit; rready follows the matching dack (dack low stalls rready).
- BUF_MASK = 2'b10, buf_empty_word = 8, channel 1 len 63 -> no AR until buf_empty_word >= 16. Channel 0 continues to issue meanwhile.
- rresp = 2'b10 on a channel-1 beat -> rd_err[1] = 1 until clr_rd_err[1]. Then cfg_dma_halt pulsed during arvalid -> the current AR completes and no further AR is issued while halt is held.
